// File: rtl/lcd_i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_i2c_pkg
// Description : Shared definitions for the LCD-over-I2C byte sequencer.
//               Contains the FSM state encoding, the bit positions inside a
//               PCF8574 backpack frame, and the HD44780 clear/home test that
//               selects the long execution delay.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_i2c_pkg;

    // ------------------------------------------------------------------------
    // FSM state encoding
    // ------------------------------------------------------------------------
    localparam int unsigned c_state_w = 3;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_req   = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_next  = 3'd4;
    localparam logic [2:0] c_st_delay = 3'd5;

    // ------------------------------------------------------------------------
    // PCF8574 frame layout: [7:4] LCD nibble, [3] backlight, [2] EN,
    // [1] RW, [0] RS
    // ------------------------------------------------------------------------
    localparam int unsigned c_bit_rs = 0;
    localparam int unsigned c_bit_rw = 1;
    localparam int unsigned c_bit_en = 2;
    localparam int unsigned c_bit_bl = 3;

    // Clear display (0x01) and return home (0x02/0x03) are the only HD44780
    // instructions that need the long execution time; both are commands
    // whose upper six bits are zero.
    function automatic logic is_clear_home(input logic rs, input logic [7:0] lcd_byte);
        return (!rs) && (lcd_byte[7:2] == 6'd0);
    endfunction

endpackage : lcd_i2c_pkg
`default_nettype wire

// File: rtl/lcd_i2c_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_i2c_byte_sequencer
// Description : Upstream feeder for the i2c_master engine. Each accepted LCD
//               byte is split into PCF8574 frames for an HD44780 in 4-bit
//               mode (high nibble first, EN pulsed high then low), each frame
//               sent as one single-byte I2C write. After the last frame the
//               HD44780 execution delay is enforced. Engine NACKs abort the
//               byte and set a sticky error flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1  system clock, rising edge
//   reset          in   1  asynchronous reset, active-low
//   in_valid       in   1  byte request valid
//   in_ready       out  1  sequencer can accept a byte (IDLE)
//   in_byte        in   8  LCD command or character
//   in_rs          in   1  1 = data (RS high), 0 = command
//   in_nibble      in   1  1 = send high nibble only (4-bit init steps)
//   backlight      in   1  level copied to PCF8574 P3 on every frame
//   i2c_ena        out  1  engine enable
//   i2c_addr       out  7  PCF8574 slave address (DEV_ADDR)
//   i2c_rw         out  1  always 0 (write)
//   i2c_data_wr    out  8  PCF8574 frame
//   i2c_busy       in   1  engine busy
//   i2c_ack_error  in   1  engine NACK flag
//   err            out  1  sticky NACK flag
//   err_clr        in   1  clears err (a same-cycle new NACK wins)
//   idle           out  1  high only in IDLE
// ============================================================================
module lcd_i2c_byte_sequencer
    import lcd_i2c_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 25_000_000,
    parameter logic [6:0]  DEV_ADDR     = 7'h27,
    parameter int unsigned SHORT_DLY_US = 50,
    parameter int unsigned LONG_DLY_US  = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       in_rs,
    input  logic       in_nibble,
    input  logic       backlight,
    output logic       i2c_ena,
    output logic [6:0] i2c_addr,
    output logic       i2c_rw,
    output logic [7:0] i2c_data_wr,
    input  logic       i2c_busy,
    input  logic       i2c_ack_error,
    output logic       err,
    input  logic       err_clr,
    output logic       idle
);

    // ------------------------------------------------------------------------
    // Delay constants: the counter is loaded with (cycles - 1) and runs to 0,
    // so DELAY occupies exactly the requested number of clock cycles.
    // ------------------------------------------------------------------------
    localparam int unsigned c_short_cnt  = (CLK_HZ / 1_000_000) * SHORT_DLY_US;
    localparam int unsigned c_long_cnt   = (CLK_HZ / 1_000_000) * LONG_DLY_US;
    localparam int unsigned c_cnt_w      = $clog2(c_long_cnt) + 1;
    localparam logic [c_cnt_w-1:0] c_short_load = c_cnt_w'(c_short_cnt - 1);
    localparam logic [c_cnt_w-1:0] c_long_load  = c_cnt_w'(c_long_cnt - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [c_state_w-1:0] r_state;
    logic [7:0]           r_byte;
    logic                 r_rs;
    logic                 r_nibble;
    logic [1:0]           r_idx;       // frame index 0..3
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_seen_low;  // busy observed low since entering REQ
    logic                 r_busy_q;    // previous-cycle busy for fall detection
    logic                 r_err;
    logic                 r_ena;
    logic [7:0]           r_data_wr;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [c_state_w-1:0] w_state_nxt;
    logic                 w_busy_fall;
    logic                 w_last;
    logic                 w_set_err;
    logic [3:0]           w_nib;
    logic [7:0]           w_frame;

    assign w_busy_fall = r_busy_q && !i2c_busy;
    assign w_last      = r_nibble ? (r_idx == 2'd1) : (r_idx == 2'd3);
    assign w_set_err   = (r_state == c_st_wait) && w_busy_fall && i2c_ack_error;

    // Frame order per byte: hi|EN, hi, lo|EN, lo. idx[1] selects the nibble,
    // idx[0] low means the EN-high half of the pulse.
    always_comb begin
        w_nib   = r_idx[1] ? r_byte[3:0] : r_byte[7:4];
        w_frame = 8'h00;
        w_frame[7:4]     = w_nib;
        w_frame[c_bit_bl] = backlight;
        w_frame[c_bit_en] = ~r_idx[0];
        w_frame[c_bit_rw] = 1'b0;
        w_frame[c_bit_rs] = r_rs;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    w_state_nxt = c_st_load;
                end
            end
            c_st_load: begin
                w_state_nxt = c_st_req;
            end
            c_st_req: begin
                // Only a busy that rose after we saw it low belongs to our
                // request; a busy already high on entry is another master.
                if (i2c_busy && r_seen_low) begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (w_busy_fall) begin
                    w_state_nxt = i2c_ack_error ? c_st_idle : c_st_next;
                end
            end
            c_st_next: begin
                w_state_nxt = w_last ? c_st_delay : c_st_load;
            end
            c_st_delay: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_byte     <= 8'h00;
            r_rs       <= 1'b0;
            r_nibble   <= 1'b0;
            r_idx      <= 2'd0;
            r_cnt      <= '0;
            r_seen_low <= 1'b0;
            r_busy_q   <= 1'b0;
            r_err      <= 1'b0;
            r_ena      <= 1'b0;
            r_data_wr  <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_busy_q <= i2c_busy;
            // ena is high for exactly the cycles spent in REQ
            r_ena    <= (w_state_nxt == c_st_req);

            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_byte   <= in_byte;
                        r_rs     <= in_rs;
                        r_nibble <= in_nibble;
                        r_idx    <= 2'd0;
                    end
                end
                c_st_load: begin
                    r_data_wr  <= w_frame;
                    r_seen_low <= 1'b0;
                end
                c_st_req: begin
                    if (!i2c_busy) begin
                        r_seen_low <= 1'b1;
                    end
                end
                c_st_next: begin
                    if (w_last) begin
                        r_cnt <= is_clear_home(r_rs, r_byte) ? c_long_load : c_short_load;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                c_st_delay: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                end
            endcase

            // A new NACK takes priority over a same-cycle clear request
            if (w_set_err) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready    = (r_state == c_st_idle);
    assign idle        = (r_state == c_st_idle);
    assign i2c_ena     = r_ena;
    assign i2c_addr    = DEV_ADDR;
    assign i2c_rw      = 1'b0;
    assign i2c_data_wr = r_data_wr;
    assign err         = r_err;

endmodule : lcd_i2c_byte_sequencer
`default_nettype wire

// File: tb/tb_lcd_i2c_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_i2c_byte_sequencer
// Description : Self-checking bench for lcd_i2c_byte_sequencer with a
//               behavioural I2C engine model that logs every transaction.
//               Table of byte vectors plus hand-written multi-cycle cases
//               (err_clr collision, back-to-back, foreign master, reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_i2c_byte_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_rs = 1'b0;
    logic       in_nibble = 1'b0;
    logic       backlight = 1'b0;
    logic       err_clr = 1'b0;
    logic       foreign_busy = 1'b0;

    logic       in_ready;
    logic       i2c_ena;
    logic [6:0] i2c_addr;
    logic       i2c_rw;
    logic [7:0] i2c_data_wr;
    logic       err;
    logic       idle;
    logic       i2c_busy;
    logic       i2c_ack_error;

    // ---------------- behavioural engine model ----------------
    logic       m_busy = 1'b0;
    logic       m_ack = 1'b0;
    int         m_phase = 0;
    int         m_cnt = 0;
    int         m_txn = 0;
    int         nack_at = -1;
    logic [7:0] m_log [0:127];

    assign i2c_busy      = m_busy | foreign_busy;
    assign i2c_ack_error = m_ack;

    always #5 clk = ~clk;

    lcd_i2c_byte_sequencer #(
        .CLK_HZ       (1_000_000),
        .DEV_ADDR     (7'h27),
        .SHORT_DLY_US (5),
        .LONG_DLY_US  (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_byte       (in_byte),
        .in_rs         (in_rs),
        .in_nibble     (in_nibble),
        .backlight     (backlight),
        .i2c_ena       (i2c_ena),
        .i2c_addr      (i2c_addr),
        .i2c_rw        (i2c_rw),
        .i2c_data_wr   (i2c_data_wr),
        .i2c_busy      (i2c_busy),
        .i2c_ack_error (i2c_ack_error),
        .err           (err),
        .err_clr       (err_clr),
        .idle          (idle)
    );

    // Engine: sees ena, raises busy one cycle later (capturing data_wr),
    // holds busy four cycles, drops it with the ack result.
    always @(posedge clk) begin
        case (m_phase)
            0: if (i2c_ena && !foreign_busy) begin
                m_phase <= 1;
                m_ack   <= 1'b0;
            end
            1: begin
                m_busy <= 1'b1;
                if (m_txn < 128) m_log[m_txn] <= i2c_data_wr;
                m_cnt   <= 3;
                m_phase <= 2;
            end
            2: if (m_cnt == 0) begin
                m_busy  <= 1'b0;
                m_ack   <= (m_txn == nack_at);
                m_txn   <= m_txn + 1;
                m_phase <= 3;
            end else begin
                m_cnt <= m_cnt - 1;
            end
            default: m_phase <= 0;
        endcase
    end

    // ---------------- edge monitor (negedge sampled) ----------------
    int   neg_cnt = 0;
    int   last_fall = 0;
    int   idle_rise = 0;
    int   ena_edges = 0;
    logic p_busy = 1'b0;
    logic p_idle = 1'b0;
    logic p_ena = 1'b0;

    always @(negedge clk) begin
        neg_cnt <= neg_cnt + 1;
        p_busy  <= i2c_busy;
        p_idle  <= idle;
        p_ena   <= i2c_ena;
        if (p_busy && !i2c_busy) last_fall <= neg_cnt;
        if (!p_idle && idle)     idle_rise <= neg_cnt;
        if (!p_ena && i2c_ena)   ena_edges <= ena_edges + 1;
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;
    int base = 0;

    typedef struct {
        logic [7:0]  b;
        logic        rs;
        logic        nib;
        logic        bl;
        int          nack;     // 0-based frame that NACKs, -1 for none
        int          nfr;      // expected transactions
        logic [31:0] fr;       // expected frames, first in MSB
        int          gap;      // negedges from last busy fall to idle
        logic        err_exp;
    } vec_t;

    vec_t vt [0:6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic offer(input string tag);
        int n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout({tag, "_accept"});
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!idle && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!idle) timeout({tag, "_idle"});
    endtask

    task automatic start_vec(input vec_t v, input string tag);
        in_byte   = v.b;
        in_rs     = v.rs;
        in_nibble = v.nib;
        backlight = v.bl;
        base      = m_txn;
        nack_at   = (v.nack < 0) ? -1 : m_txn + v.nack;
        offer(tag);
        in_valid  = 1'b0;
    endtask

    task automatic finish_vec(input vec_t v, input string tag);
        wait_idle(tag);
        @(negedge clk);
        chk({tag, "_nframes"}, m_txn - base, v.nfr);
        for (int k = 0; k < v.nfr; k++) begin
            chk($sformatf("%s_frame%0d", tag, k), {24'd0, m_log[base + k]}, {24'd0, v.fr[31 - 8*k -: 8]});
        end
        chk({tag, "_delay"}, idle_rise - last_fall, v.gap);
        chk({tag, "_err"}, err, v.err_exp);
        nack_at = -1;
    endtask

    initial begin
        int   n;
        logic pb;
        logic found;
        logic [7:0] b2b [0:7];

        vt[0] = '{8'h41, 1'b1, 1'b0, 1'b1, -1, 4, 32'h4D491D19, 7,  1'b0};
        vt[1] = '{8'h01, 1'b0, 1'b0, 1'b1, -1, 4, 32'h0C081C18, 22, 1'b0};
        vt[2] = '{8'h30, 1'b0, 1'b1, 1'b0, -1, 2, 32'h34300000, 7,  1'b0};
        vt[3] = '{8'h02, 1'b0, 1'b0, 1'b0, -1, 4, 32'h04002420, 22, 1'b0};
        vt[4] = '{8'h03, 1'b1, 1'b0, 1'b1, -1, 4, 32'h0D093D39, 7,  1'b0};
        vt[5] = '{8'h04, 1'b0, 1'b0, 1'b0, -1, 4, 32'h04004440, 7,  1'b0};
        vt[6] = '{8'h41, 1'b1, 1'b0, 1'b1, 1,  2, 32'h4D490000, 1,  1'b1};

        b2b[0] = 8'h4D; b2b[1] = 8'h49; b2b[2] = 8'h8D; b2b[3] = 8'h89;
        b2b[4] = 8'h4D; b2b[5] = 8'h49; b2b[6] = 8'h9D; b2b[7] = 8'h99;

        // reset state
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_ena", i2c_ena, 0);
        chk("rst_data_wr", i2c_data_wr, 8'h00);
        chk("rst_err", err, 0);
        chk("rst_addr", i2c_addr, 7'h27);
        chk("rst_rw", i2c_rw, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // table-driven byte vectors
        for (int i = 0; i < 7; i++) begin
            start_vec(vt[i], $sformatf("vec%0d", i));
            finish_vec(vt[i], $sformatf("vec%0d", i));
        end

        // err_clr alone clears, then a NACK in the clear cycle keeps err set
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", err, 0);
        in_byte = 8'h41; in_rs = 1'b1; in_nibble = 1'b0; backlight = 1'b1;
        base = m_txn;
        nack_at = m_txn;
        offer("collide");
        in_valid = 1'b0;
        pb = i2c_busy;
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            @(negedge clk);
            if (pb && !i2c_busy) found = 1'b1;
            else begin
                pb = i2c_busy;
                n++;
            end
        end
        if (!found) timeout("collide_fall");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_set_beats_clr", err, 1);
        wait_idle("collide");
        @(negedge clk);
        chk("collide_nframes", m_txn - base, 1);
        nack_at = -1;

        // back-to-back with in_valid held
        base = m_txn;
        n = ena_edges;
        in_rs = 1'b1; in_nibble = 1'b0; backlight = 1'b1;
        in_byte = 8'h48;
        offer("b2b_a");
        in_byte = 8'h49;
        offer("b2b_b");
        in_valid = 1'b0;
        wait_idle("b2b");
        @(negedge clk);
        chk("b2b_nframes", m_txn - base, 8);
        chk("b2b_ena_pulses", ena_edges - n, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("b2b_frame%0d", k), {24'd0, m_log[base + k]}, {24'd0, b2b[k]});
        end

        // foreign master holds busy before our request
        foreign_busy = 1'b1;
        start_vec(vt[0], "foreign");
        repeat (10) @(negedge clk);
        chk("foreign_no_txn", m_txn - base, 0);
        chk("foreign_ena_held", i2c_ena, 1);
        foreign_busy = 1'b0;
        // err is still set from the collision case
        vt[0].err_exp = 1'b1;
        finish_vec(vt[0], "foreign");
        vt[0].err_exp = 1'b0;

        // asynchronous reset while waiting on the engine
        in_byte = 8'h41; in_rs = 1'b1; in_nibble = 1'b0; backlight = 1'b1;
        offer("rstwait");
        in_valid = 1'b0;
        n = 0;
        while (!i2c_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!i2c_busy) timeout("rstwait_busy");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rstwait_ena", i2c_ena, 0);
        chk("rstwait_idle", idle, 1);
        chk("rstwait_err", err, 0);
        chk("rstwait_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while ((m_phase != 0 || i2c_busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (m_phase != 0 || i2c_busy) timeout("rstwait_engine");
        @(negedge clk);
        start_vec(vt[0], "after_rst");
        finish_vec(vt[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_lcd_i2c_byte_sequencer
`default_nettype wire
